// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared types for the stream_demux block.
//   state_t : packet-tracking state. IDLE means the next accepted beat starts
//             a new packet (its select is sampled); LOCKED means a packet is
//             in progress and the destination port is frozen.
// ----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage : demux_pkg

// File: rtl/stream_demux_if.sv
// ----------------------------------------------------------------------------
// stream_demux_if
// Bundles the input valid/ready stream and the D per-port output streams of
// the stream demultiplexer.
//   Parameters : A (select width), W (data width); D = 2**A is derived.
//   s_valid/s_ready/s_data/s_select/s_last : input stream
//   m_valid/m_ready/m_data/m_last          : D output streams
//   modport master : the side that feeds the input and consumes the outputs
//   modport slave  : the demultiplexer itself
// ----------------------------------------------------------------------------
interface stream_demux_if #(
    parameter int A = 2,
    parameter int W = 32
);
    localparam int D = 1 << A;

    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic [A-1:0]   s_select;
    logic           s_last;

    logic [D-1:0]   m_valid;
    logic [D-1:0]   m_ready;
    logic [W-1:0]   m_data [D];
    logic [D-1:0]   m_last;

    modport master (
        output s_valid, s_data, s_select, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_select, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface : stream_demux_if

// File: rtl/stream_demux_recursive_decoder.sv
// ----------------------------------------------------------------------------
// recursive_decoder
// Combinational A-to-2**A one-hot decoder with enable. Built by halving: the
// top select bit steers the enable into the lower or upper half, each half
// being a decoder one bit narrower, down to a 1-bit leaf.
//   i_en     : enable; all outputs are 0 when low
//   i_sel    : binary index, A bits (A >= 1)
//   o_onehot : 2**A bits, bit i_sel set when i_en is high
// ----------------------------------------------------------------------------
module recursive_decoder #(
    parameter int A = 2
) (
    input  logic                i_en,
    input  logic [A-1:0]        i_sel,
    output logic [(1<<A)-1:0]   o_onehot
);

    generate
        if (A == 1) begin : g_leaf
            assign o_onehot = {i_en & i_sel[0], i_en & ~i_sel[0]};
        end else begin : g_split
            localparam int H = 1 << (A - 1);
            logic w_en_lo;
            logic w_en_hi;

            assign w_en_lo = i_en & ~i_sel[A-1];
            assign w_en_hi = i_en &  i_sel[A-1];

            recursive_decoder #(.A(A - 1)) u_lo (
                .i_en     (w_en_lo),
                .i_sel    (i_sel[A-2:0]),
                .o_onehot (o_onehot[H-1:0])
            );

            recursive_decoder #(.A(A - 1)) u_hi (
                .i_en     (w_en_hi),
                .i_sel    (i_sel[A-2:0]),
                .o_onehot (o_onehot[2*H-1:H])
            );
        end
    endgenerate

endmodule : recursive_decoder

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
// Registered 1-to-D stream demultiplexer. Each packet is routed whole to the
// output port chosen by s_select on its first beat; one output register
// stage gives 1 beat/clk throughput and 1 clk latency.
//   aclk    : clock, rising edge
//   aresetn : asynchronous active-low reset (deassertion synchronised outside)
//   bus     : stream_demux_if.slave (input stream + D output streams)
//   busy    : high while a packet is in flight (LOCKED or register full)
// ----------------------------------------------------------------------------
module stream_demux
    import demux_pkg::*;
#(
    parameter int A = 2,
    parameter int W = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    stream_demux_if.slave   bus,
    output logic            busy
);

    localparam int D = 1 << A;

    state_t         r_state;
    state_t         w_state_next;
    logic [A-1:0]   r_sel;
    logic [A-1:0]   w_sel_next;
    logic [W-1:0]   r_data;
    logic [W-1:0]   w_data_next;
    logic           r_last;
    logic           w_last_next;
    logic           r_valid;
    logic           w_valid_next;
    // Holds s_ready low during reset and releases it from the first edge after.
    logic           r_run;

    logic           w_sel_ready;
    logic           w_hs;
    logic           w_unload;

    // Only the selected port's ready matters; the others are ignored.
    assign w_sel_ready = bus.m_ready[r_sel];
    assign bus.s_ready = r_run & (~r_valid | w_sel_ready);
    assign w_hs        = bus.s_valid & bus.s_ready;
    assign w_unload    = r_valid & w_sel_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_data  <= w_data_next;
            r_last  <= w_last_next;
            r_valid <= w_valid_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_data_next  = r_data;
        w_last_next  = r_last;
        w_valid_next = r_valid;

        // A load wins over an unload, so unload+load in one cycle keeps
        // valid high with no bubble.
        if (w_hs) begin
            w_valid_next = 1'b1;
            w_data_next  = bus.s_data;
            w_last_next  = bus.s_last;
        end else if (w_unload) begin
            w_valid_next = 1'b0;
        end

        case (r_state)
            IDLE: begin
                // In IDLE a handshake can only happen when the register is
                // empty or unloading, so a pending beat is never redirected.
                if (w_hs) begin
                    w_sel_next = bus.s_select;
                    if (!bus.s_last) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_hs && bus.s_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    recursive_decoder #(.A(A)) u_valid_dec (
        .i_en     (r_valid),
        .i_sel    (r_sel),
        .o_onehot (bus.m_valid)
    );

    recursive_decoder #(.A(A)) u_last_dec (
        .i_en     (r_last),
        .i_sel    (r_sel),
        .o_onehot (bus.m_last)
    );

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_data
            assign bus.m_data[gi] = r_data;
        end
    endgenerate

    assign busy = (r_state == LOCKED) | r_valid;

endmodule : stream_demux
